// File: rtl/urcpu_pkg.sv
// urcpu_pkg: shared URCPU word size and word type
package urcpu_pkg;
    localparam int WORD_W = 20;
    typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/popcount.sv
// popcount: combinational count of set bits
module popcount #(
    parameter int WIDTH = 20,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] x,
    output logic [CNT_W-1:0] cnt
);
    always_comb begin
        cnt = '0;
        for (int i = 0; i < WIDTH; i++)
            cnt = cnt + CNT_W'(x[i]);
    end
endmodule

// File: rtl/and_gate.sv
// and_gate: combinational a & b plus registered result and status flags
module and_gate
    import urcpu_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] c_q,
    output logic             out_valid,
    output logic             zero_q,
    output logic             ones_q,
    output logic [CNT_W-1:0] popcnt_q
);
    logic [CNT_W-1:0] cnt;

    assign c = a & b;

    popcount #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_popcount (.x(c), .cnt(cnt));

    // flags are captured alongside c_q so they always describe the same result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q       <= '0;
            zero_q    <= 1'b1;
            ones_q    <= 1'b0;
            popcnt_q  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                c_q      <= c;
                zero_q   <= ~|c;
                ones_q   <= &c;
                popcnt_q <= cnt;
            end
        end
    end
endmodule

// File: tb/tb_and_gate.sv
// tb_and_gate: directed table plus random sweep and async reset checks for and_gate
module tb_and_gate;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [19:0] a = '0;
    logic [19:0] b = '0;
    logic        in_valid = 1'b0;
    logic [19:0] c, c_q;
    logic        out_valid, zero_q, ones_q;
    logic [4:0]  popcnt_q;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic [19:0] a, b;
        logic        v;
        logic [19:0] c_q;
        logic        zero, ones;
        logic [4:0]  pop;
        logic        ov;
    } vec_t;

    vec_t vecs[7];

    and_gate dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
        .c(c), .c_q(c_q), .out_valid(out_valid), .zero_q(zero_q),
        .ones_q(ones_q), .popcnt_q(popcnt_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_regs(input string tag, input logic [19:0] ecq, input logic ez,
                            input logic eo, input logic [4:0] ep, input logic eov);
        chk({tag, " c_q"}, 64'(c_q), 64'(ecq));
        chk({tag, " zero_q"}, 64'(zero_q), 64'(ez));
        chk({tag, " ones_q"}, 64'(ones_q), 64'(eo));
        chk({tag, " popcnt_q"}, 64'(popcnt_q), 64'(ep));
        chk({tag, " out_valid"}, 64'(out_valid), 64'(eov));
    endtask

    initial begin
        logic [19:0] g;
        int seed;
        vecs[0] = '{20'hF0F0F, 20'hFF00F, 1'b1, 20'hF000F, 1'b0, 1'b0, 5'd8,  1'b1};
        vecs[1] = '{20'h00000, 20'h00000, 1'b0, 20'hF000F, 1'b0, 1'b0, 5'd8,  1'b0};
        vecs[2] = '{20'hFFFFF, 20'hFFFFF, 1'b1, 20'hFFFFF, 1'b0, 1'b1, 5'd20, 1'b1};
        vecs[3] = '{20'hAAAAA, 20'h55555, 1'b1, 20'h00000, 1'b1, 1'b0, 5'd0,  1'b1};
        vecs[4] = '{20'h12345, 20'hFFFFF, 1'b0, 20'h00000, 1'b1, 1'b0, 5'd0,  1'b0};
        vecs[5] = '{20'h00001, 20'h00001, 1'b1, 20'h00001, 1'b0, 1'b0, 5'd1,  1'b1};
        vecs[6] = '{20'h80000, 20'hC0000, 1'b1, 20'h80000, 1'b0, 1'b0, 5'd1,  1'b1};

        // reset held with random operands and in_valid high
        seed = $urandom(49448);
        a = 20'($urandom);
        b = 20'($urandom);
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_regs("reset", 20'h0, 1'b1, 1'b0, 5'd0, 1'b0);
        chk("reset c", 64'(c), 64'(a & b));

        // release reset between edges, then combinational path without clocking
        in_valid = 1'b0;
        rst_n = 1'b1;
        a = 20'hFFFFF;
        b = 20'h5A5A5;
        #1;
        chk("comb c", 64'(c), 64'h5A5A5);
        a = 20'h0;
        #1;
        chk("comb c zero", 64'(c), 64'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            a = vecs[i].a;
            b = vecs[i].b;
            in_valid = vecs[i].v;
            #1;
            chk($sformatf("vec%0d c", i), 64'(c), 64'(vecs[i].a & vecs[i].b));
            @(posedge clk);
            #1;
            chk_regs($sformatf("vec%0d", i), vecs[i].c_q, vecs[i].zero, vecs[i].ones,
                     vecs[i].pop, vecs[i].ov);
        end

        // back-to-back random captures against a golden result
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a = 20'($urandom);
            b = 20'($urandom);
            in_valid = 1'b1;
            g = a & b;
            #1;
            chk($sformatf("rnd%0d c", i), 64'(c), 64'(g));
            @(posedge clk);
            #1;
            chk_regs($sformatf("rnd%0d", i), g, g == 20'h0, g == 20'hFFFFF,
                     5'($countones(g)), 1'b1);
        end

        // async reset between edges while out_valid is high
        #2;
        rst_n = 1'b0;
        #1;
        chk_regs("async rst", 20'h0, 1'b1, 1'b0, 5'd0, 1'b0);
        chk("async rst c", 64'(c), 64'(a & b));
        @(posedge clk);
        #1;
        chk_regs("rst held", 20'h0, 1'b1, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        a = 20'h0F0F0;
        b = 20'h0FFFF;
        @(posedge clk);
        #1;
        chk_regs("post rst", 20'h0F0F0, 1'b0, 1'b0, 5'd8, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
